// File: rtl/alu_seq_unit.sv
// Sequential ALU: one op per start, CALC for single-cycle ops, SHIFT for bit-serial shifts.
// Define ALU_SEQ_FAST_SHIFT_EN to route shifts through a barrel shifter in CALC instead.
//
// state | meaning
// IDLE  | waiting for start
// CALC  | operands latched, result registered on next edge
// SHIFT | one bit per edge until the counter reaches zero
// DONE  | done pulse; may accept a new start back-to-back
module alu_seq_unit (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [2:0]  ALUControl,
   input  logic        aluflag,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        flush,
   output logic [31:0] result,
   output logic        zero,
   output logic        overflow,
   output logic        busy,
   output logic        done
);

   typedef enum logic [1:0] {S_IDLE, S_CALC, S_SHIFT, S_DONE} state_t;
   typedef enum logic [3:0] {
      OP_ADD, OP_SUB, OP_AND, OP_SRL, OP_SRA,
      OP_SLTU, OP_SLT, OP_XOR, OP_SLL, OP_OR
   } op_t;

   state_t      state, state_nxt;
   op_t         op_dec, op_q;
   logic [31:0] a_q, b_q;
   logic        accept;
   logic        dec_shift;
   logic [31:0] alu_res;
   logic        alu_ovf;
   logic [31:0] sum, diff;

   assign accept = start && !flush && (state == S_IDLE || state == S_DONE);

   always_comb begin
      op_dec = OP_ADD;
      case ({ALUControl, aluflag})
         4'b0000, 4'b0001: op_dec = OP_ADD;
         4'b0010, 4'b0011: op_dec = OP_SUB;
         4'b0100, 4'b0101: op_dec = OP_AND;
         4'b0110:          op_dec = OP_SRL;
         4'b0111:          op_dec = OP_SRA;
         4'b1000:          op_dec = OP_AND;
         4'b1001:          op_dec = OP_SLTU;
         4'b1010, 4'b1011: op_dec = OP_SLT;
         4'b1100:          op_dec = OP_XOR;
         4'b1101:          op_dec = OP_SLL;
         4'b1110, 4'b1111: op_dec = OP_OR;
         default:          op_dec = OP_ADD;
      endcase
   end

`ifdef ALU_SEQ_FAST_SHIFT_EN
   assign dec_shift = 1'b0;
`else
   assign dec_shift = (op_dec == OP_SRL) || (op_dec == OP_SRA) || (op_dec == OP_SLL);

   logic [4:0]  cnt;
   logic [31:0] sh_q;
   logic [31:0] sh_step;
   logic        shift_last;

   assign shift_last = (state == S_SHIFT) && (cnt == 5'd0);

   always_comb begin
      sh_step = {1'b0, sh_q[31:1]};
      case (op_q)
         OP_SLL:  sh_step = {sh_q[30:0], 1'b0};
         OP_SRA:  sh_step = {sh_q[31], sh_q[31:1]};
         default: sh_step = {1'b0, sh_q[31:1]};
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt  <= 5'd0;
         sh_q <= 32'd0;
      end else if (accept && dec_shift) begin
         cnt  <= b[4:0];
         sh_q <= a;
      end else if (flush) begin
         cnt  <= 5'd0;
      end else if (state == S_SHIFT && cnt != 5'd0) begin
         cnt  <= cnt - 5'd1;
         sh_q <= sh_step;
      end
   end
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      if (flush) begin
         state_nxt = S_IDLE;
      end else begin
         case (state)
            S_IDLE:  if (start) state_nxt = dec_shift ? S_SHIFT : S_CALC;
            S_CALC:  state_nxt = S_DONE;
            S_SHIFT: begin
`ifdef ALU_SEQ_FAST_SHIFT_EN
               state_nxt = S_IDLE;
`else
               if (cnt == 5'd0) state_nxt = S_DONE;
`endif
            end
            S_DONE:  state_nxt = start ? (dec_shift ? S_SHIFT : S_CALC) : S_IDLE;
            default: state_nxt = S_IDLE;
         endcase
      end
   end

   always_comb begin
      busy = 1'b0;
      done = 1'b0;
      case (state)
         S_CALC, S_SHIFT: busy = 1'b1;
         S_DONE:          done = 1'b1;
         default:         ;
      endcase
   end

   // Operands are captured only at acceptance so later input changes cannot leak in.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_q <= OP_ADD;
         a_q  <= 32'd0;
         b_q  <= 32'd0;
      end else if (accept) begin
         op_q <= op_dec;
         a_q  <= a;
         b_q  <= b;
      end
   end

   assign sum  = a_q + b_q;
   assign diff = a_q - b_q;

   always_comb begin
      alu_res = 32'd0;
      alu_ovf = 1'b0;
      case (op_q)
         OP_ADD: begin
            alu_res = sum;
            alu_ovf = (a_q[31] == b_q[31]) && (sum[31] != a_q[31]);
         end
         OP_SUB: begin
            alu_res = diff;
            alu_ovf = (a_q[31] != b_q[31]) && (diff[31] != a_q[31]);
         end
         OP_AND:  alu_res = a_q & b_q;
         OP_OR:   alu_res = a_q | b_q;
         OP_XOR:  alu_res = a_q ^ b_q;
         OP_SLT:  alu_res = {31'd0, $signed(a_q) < $signed(b_q)};
         OP_SLTU: alu_res = {31'd0, a_q < b_q};
`ifdef ALU_SEQ_FAST_SHIFT_EN
         OP_SLL:  alu_res = a_q << b_q[4:0];
         OP_SRL:  alu_res = a_q >> b_q[4:0];
         OP_SRA:  alu_res = $unsigned($signed(a_q) >>> b_q[4:0]);
`endif
         default: alu_res = 32'd0;
      endcase
   end

   // Outputs hold between completions; a flush never updates them.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         result   <= 32'd0;
         zero     <= 1'b1;
         overflow <= 1'b0;
      end else if (!flush) begin
         if (state == S_CALC) begin
            result   <= alu_res;
            zero     <= (alu_res == 32'd0);
            overflow <= alu_ovf;
         end
`ifndef ALU_SEQ_FAST_SHIFT_EN
         else if (shift_last) begin
            result   <= sh_q;
            zero     <= (sh_q == 32'd0);
            overflow <= 1'b0;
         end
`endif
      end
   end

endmodule

// File: tb/tb_alu_seq_unit.sv
// Scoreboard bench for alu_seq_unit: stimulus pushes expected results, a negedge monitor checks on done.
module tb_alu_seq_unit;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [2:0]  ALUControl;
   logic        aluflag;
   logic [31:0] a;
   logic [31:0] b;
   logic        flush;
   logic [31:0] result;
   logic        zero;
   logic        overflow;
   logic        busy;
   logic        done;

   typedef struct packed {
      logic [31:0] res;
      logic        z;
      logic        ov;
   } exp_t;

   exp_t exp_q[$];
   exp_t e;
   int   total = 0;
   int   bad   = 0;

   alu_seq_unit dut (
      .clk(clk), .rst_n(rst_n), .start(start), .ALUControl(ALUControl),
      .aluflag(aluflag), .a(a), .b(b), .flush(flush), .result(result),
      .zero(zero), .overflow(overflow), .busy(busy), .done(done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %h want %h (t=%0t)", name, act, req, $time);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n === 1'b1 && done === 1'b1) begin
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_done: got done with result %h want no done (t=%0t)", result, $time);
         end else begin
            e = exp_q.pop_front();
            check("result", result, e.res);
            check("zero", 32'(zero), 32'(e.z));
            check("overflow", 32'(overflow), 32'(e.ov));
         end
      end
   end

   function automatic int shlat(input int shamt);
`ifdef ALU_SEQ_FAST_SHIFT_EN
      return 1;
`else
      return shamt + 1;
`endif
   endfunction

   // Call right after a negedge; returns at the negedge where done is seen.
   task automatic do_op(input logic [2:0] ctl, input logic fl, input logic [31:0] av,
                        input logic [31:0] bv, input logic [31:0] er, input logic eov,
                        input int elat, input bit poke);
      int lat;
      int bcnt;
      ALUControl = ctl; aluflag = fl; a = av; b = bv; start = 1'b1;
      exp_q.push_back({er, (er == 32'd0), eov});
      @(negedge clk);
      start = 1'b0;
      a = 32'hDEAD_BEEF;
      b = 32'h1234_5673;
      check("done_low_after_accept", 32'(done), 32'd0);
      lat  = 0;
      bcnt = busy ? 1 : 0;
      while (!done && lat < 200) begin
         if (poke && busy) begin
            start = 1'b1; a = 32'd0; ALUControl = 3'b000; aluflag = 1'b0;
         end else begin
            start = 1'b0;
         end
         @(negedge clk);
         start = 1'b0;
         lat++;
         if (!done && busy) bcnt++;
      end
      check("latency", lat, elat);
      if (poke) check("busy_cycles", bcnt, elat);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: got no finish want finish");
      $fatal(1, "timeout");
   end

   initial begin
      rst_n = 1'b0; start = 1'b0; flush = 1'b0;
      ALUControl = 3'b000; aluflag = 1'b0; a = 32'd0; b = 32'd0;
      repeat (2) @(negedge clk);
      check("rst_result", result, 32'd0);
      check("rst_zero", 32'(zero), 32'd1);
      check("rst_overflow", 32'(overflow), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      rst_n = 1'b1;

      do_op(3'b000, 1'b0, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 1'b1, 1, 0);
      @(negedge clk);
      check("done_one_cycle", 32'(done), 32'd0);
      do_op(3'b000, 1'b1, 32'd2, 32'd3, 32'd5, 1'b0, 1, 0);
      @(negedge clk);
      do_op(3'b001, 1'b1, 32'h8000_0000, 32'h1, 32'h7FFF_FFFF, 1'b1, 1, 0);
      @(negedge clk);
      do_op(3'b010, 1'b1, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000, 1'b0, 1, 0);
      @(negedge clk);
      do_op(3'b100, 1'b0, 32'h0F0F_0F0F, 32'h00FF_00FF, 32'h000F_000F, 1'b0, 1, 0);
      @(negedge clk);
      do_op(3'b100, 1'b1, 32'h1, 32'hFFFF_FFFF, 32'h1, 1'b0, 1, 0);
      @(negedge clk);
      do_op(3'b101, 1'b0, 32'h1, 32'hFFFF_FFFF, 32'h0, 1'b0, 1, 0);
      @(negedge clk);
      do_op(3'b011, 1'b1, 32'h8000_0000, 32'd4, 32'hF800_0000, 1'b0, shlat(4), 1);
      @(negedge clk);
      do_op(3'b011, 1'b0, 32'h8000_0000, 32'd4, 32'h0800_0000, 1'b0, shlat(4), 0);
      @(negedge clk);
      do_op(3'b110, 1'b1, 32'h1, 32'd0, 32'h1, 1'b0, shlat(0), 0);
      @(negedge clk);
      do_op(3'b110, 1'b1, 32'h3, 32'd2, 32'hC, 1'b0, shlat(2), 0);
      @(negedge clk);
      do_op(3'b110, 1'b1, 32'h1, 32'd31, 32'h8000_0000, 1'b0, shlat(31), 0);
      @(negedge clk);

      // back-to-back: second start issued while first is in DONE
      do_op(3'b001, 1'b0, 32'd5, 32'd5, 32'd0, 1'b0, 1, 0);
      do_op(3'b110, 1'b0, 32'h0000_00F0, 32'h0000_000F, 32'h0000_00FF, 1'b0, 1, 0);
      @(negedge clk);
      do_op(3'b111, 1'b0, 32'h0000_00A0, 32'h0000_0005, 32'h0000_00A5, 1'b0, 1, 0);
      @(negedge clk);

      // flush during CALC
      ALUControl = 3'b000; aluflag = 1'b0; a = 32'd9; b = 32'd9; start = 1'b1;
      @(negedge clk);
      start = 1'b0; flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      check("flush_calc_busy", 32'(busy), 32'd0);
      check("flush_calc_result", result, 32'h0000_00A5);

      // flush beats a simultaneous start
      start = 1'b1; flush = 1'b1;
      @(negedge clk);
      start = 1'b0; flush = 1'b0;
      check("flush_vs_start_busy", 32'(busy), 32'd0);
      repeat (3) @(negedge clk);

`ifndef ALU_SEQ_FAST_SHIFT_EN
      ALUControl = 3'b110; aluflag = 1'b1; a = 32'h1; b = 32'd31; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (5) @(negedge clk);
      check("shift_busy_mid", 32'(busy), 32'd1);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      check("flush_shift_busy", 32'(busy), 32'd0);
      check("flush_shift_done", 32'(done), 32'd0);
      check("flush_shift_result", result, 32'h0000_00A5);
      repeat (40) @(negedge clk);

      ALUControl = 3'b110; aluflag = 1'b1; a = 32'h1; b = 32'd31; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("midrst_result", result, 32'd0);
      check("midrst_zero", 32'(zero), 32'd1);
      check("midrst_overflow", 32'(overflow), 32'd0);
      check("midrst_busy", 32'(busy), 32'd0);
      check("midrst_done", 32'(done), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (40) @(negedge clk);
`else
      do_op(3'b110, 1'b1, 32'h1, 32'd31, 32'h8000_0000, 1'b0, 1, 0);
      @(negedge clk);
`endif

      // first start right after reset release / idle
      do_op(3'b000, 1'b0, 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b0, 1, 0);
      repeat (3) @(negedge clk);

      check("queue_empty", exp_q.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/alu_seq_unit.md
ALU_SEQ_UNIT -- requirements
Module: alu_seq_unit

Interface
REQ-001 SHALL have ports: clk  input  1  rising-edge clock, single clock domain.
REQ-002 SHALL have: rst_n  input  1  asynchronous, active-low reset.
REQ-003 SHALL have: start  input  1  request; sampled on clk rising edge.
REQ-004 SHALL have: ALUControl  input  3  op code from the ALU decoder.
REQ-005 SHALL have: aluflag  input  1  op qualifier from the ALU decoder.
REQ-006 SHALL have: a, b  input  32 each  operands; shift amount = b[4:0].
REQ-007 SHALL have: flush  input  1  synchronous abort.
REQ-008 SHALL have: result  output  32  registered result.
REQ-009 SHALL have: zero  output  1  registered, result==0.
REQ-010 SHALL have: overflow  output  1  registered signed overflow, add/sub only.
REQ-011 SHALL have: busy  output  1  high in CALC/SHIFT.
REQ-012 SHALL have: done  output  1  one-cycle completion pulse.

Function
REQ-013 SHALL decode {ALUControl,aluflag}: 000x add; 001x sub; 010x AND; 0110 SRL; 0111 SRA; 1000 AND; 1001 SLTU; 101x SLT; 1100 XOR; 1101 SLL; 111x OR.
REQ-014 SHALL ignore aluflag wherever REQ-013 marks it x.
REQ-015 SHALL implement FSM states IDLE, CALC, SHIFT, DONE; done=1 only in DONE; busy=1 only in CALC/SHIFT.
REQ-016 SHALL accept start only in IDLE or DONE; on acceptance latch op, a, b; enter SHIFT for SRL/SRA/SLL, else CALC.
REQ-017 SHALL ignore start while busy; latched operands unaffected by input changes after acceptance.
REQ-018 CALC SHALL register result/zero/overflow on the next edge and go to DONE: done high after edge N+1 where N is the accept edge.
REQ-019 SHIFT SHALL load counter=b[4:0]; each edge with counter>0 shifts 1 bit and decrements; at counter==0 registers result and goes to DONE: done after edge N+1+shamt (shamt 0 -> result=a at N+1).
REQ-020 SRA SHALL replicate bit 31; SRL/SLL SHALL fill zeros.
REQ-021 add/sub SHALL wrap modulo 2^32; overflow per two's-complement sign rule; overflow=0 for other ops.
REQ-022 SLT signed, SLTU unsigned; result 32'h1 or 32'h0.
REQ-023 DONE SHALL return to IDLE next edge unless start is accepted (back-to-back).
REQ-024 result/zero/overflow SHALL hold their last value until the next completion.
REQ-025 flush high at an edge SHALL force IDLE with no done pulse; result unchanged; flush wins over simultaneous start.

Reset
REQ-026 rst_n low SHALL immediately force IDLE, result=0, zero=1, overflow=0, busy=0, done=0, counter=0.
REQ-027 reset mid-operation SHALL discard the operation; no done after release.
REQ-028 first start SHALL be accepted on the first rising edge with rst_n high.

Configuration
REQ-029 macro ALU_SEQ_FAST_SHIFT_EN defined: shifts SHALL use a single-cycle barrel shifter via CALC; all ops complete at N+1; SHIFT state unused.
REQ-030 macro undefined: shifts SHALL be iterative per REQ-019; latency shamt+1.

Verification
REQ-031 add a=7FFFFFFF, b=1 -> after N+1: result=80000000, overflow=1, zero=0, done one cycle.
REQ-032 SRA a=80000000, b=4 (0111), macro off -> done at N+5, result=F8000000; busy 4..5 cycles high; start during busy ignored.
REQ-033 SLTU a=1, b=FFFFFFFF -> result=1; SLT same operands -> result=0.
REQ-034 sub a=5, b=5 then back-to-back start in DONE with XOR a=F0, b=0F -> results 0 (zero=1) then FF (zero=0), no idle gap.
REQ-035 SLL b=31 with flush asserted mid-shift -> IDLE next edge, no done, result holds prior value; repeat with rst_n pulse -> reset values.
REQ-036 macro on: SLL a=1, b=31 -> result=80000000 at N+1.
